hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Pipeline sequencing controller for the 5-stage 16-bit pipeline. Sits beside the forwarding unit.
- Detects load-use hazards that forwarding cannot cover and inserts one bubble.
- Flushes wrong-path instructions after a taken branch resolved in EX.
- Freezes the whole pipe while data memory is busy.
- Drives all pipeline-register write enables and flush/bubble controls.

Parameters:
- REG_ADDR_W, 3, register address width (8-entry register file).
- FLUSH_CYCLES, 1, total flush cycles per taken branch, including the resolve cycle; legal range 1..7.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- id_src_addr  in  REG_ADDR_W  source register of the instruction in ID
- id_dst_addr  in  REG_ADDR_W  destination register of the instruction in ID (also read as an operand)
- id_src_used  in  1  ID instruction reads src
- id_dst_used  in  1  ID instruction reads dst
- ex_dst_addr  in  REG_ADDR_W  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- branch_taken  in  1  EX branch resolved taken
- mem_busy  in  1  data memory not ready this cycle
- pc_we  out  1  PC write enable
- if_id_we  out  1  IF/ID write enable
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_bubble  out  1  ID/EX loads NOP
- back_we  out  1  EX/MEM and MEM/WB write enable
- state_o  out  2  current FSM state (debug)
- stall_cnt, flush_cnt, memwait_cnt  out  CNT_W each  performance counters (see Optional Feature)

Behaviour:
- States: RUN=0, FLUSH=1, MEM_WAIT=2. Encoding 3 is illegal and recovers to RUN next cycle.
- Outputs are Mealy: a function of the current state and current inputs. The state register updates on the rising edge of clk.
- Reset: rst=1 at a clock edge sets state=RUN, flush counter=0, resume state=RUN, all counters=0.
  - While rst=1, outputs are forced to pc_we=0, if_id_we=0, if_id_flush=1, id_ex_bubble=1, back_we=0.
  - Reset mid-stall or mid-flush aborts that sequence; no residual state remains.
- Load-use hazard: luh = ex_mem_read & ((id_src_used & id_src_addr==ex_dst_addr) | (id_dst_used & id_dst_addr==ex_dst_addr)).
- Priority in every state: rst > mem_busy > branch_taken > luh.
- RUN, default cycle: all enables=1, if_id_flush=0, id_ex_bubble=0.
- RUN, luh=1: pc_we=0, if_id_we=0, id_ex_bubble=1, back_we=1. Stay in RUN.
  - Latency: exactly one bubble. Next cycle the load is in MEM, luh evaluates 0, and forwarding supplies the data.
- RUN, branch_taken=1: pc_we=1 (target load), if_id_flush=1, id_ex_bubble=1, back_we=1.
  - If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1; otherwise stay in RUN.
  - A simultaneous luh is ignored.
- FLUSH: pc_we=1, if_id_flush=1, id_ex_bubble=1, back_we=1. Counter decrements each cycle.
  - Counter==1 → RUN.
  - branch_taken and luh are ignored in FLUSH.
- mem_busy=1 in RUN or FLUSH: all write enables=0, if_id_flush=0, id_ex_bubble=0.
  - Save the resume state and counter, then go to MEM_WAIT.
- MEM_WAIT: same outputs as mem_busy=1 while mem_busy=1.
  - On the first cycle with mem_busy=0, return to the saved state with the counter unchanged, and evaluate that state's rules in the same cycle.
  - A held branch_taken or luh is therefore serviced on exit, never lost.
- Simultaneous mem_busy and branch_taken: freeze wins; the branch is flushed on the first non-busy cycle.
- Each hazard decision uses only current inputs; no instruction is ever issued twice or skipped.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each luh stall cycle.
  - flush_cnt increments on each cycle with if_id_flush=1 and rst=0.
  - memwait_cnt increments on each mem_busy freeze cycle.
  - All counters saturate at 2^CNT_W-1 and clear on rst.
- Not defined: the three counter ports are tied to 0 and no counter flops exist.

Decomposition:
- Package hazard_pkg holds:
  - state type (RUN/FLUSH/MEM_WAIT)
  - REG_ADDR_W default
  - NOP control constants
- Sub-module hazard_perf_counters: three saturating counters, instantiated only under HAZARD_PERF_CNT_EN.

Test Plan:
- Load R3 in EX (ex_mem_read=1, ex_dst_addr=3), ID src=3 with src_used=1 → same cycle pc_we=0, if_id_we=0, id_ex_bubble=1. Next cycle (ex_mem_read=0) all enables=1. stall_cnt=1.
- Load R3, ID dst=3 with dst_used=0 and src=5 → no stall. Repeat with dst_used=1 → stall.
- FLUSH_CYCLES=3, branch_taken pulse → if_id_flush=1 for 3 consecutive cycles, state_o sequence RUN,FLUSH,FLUSH,RUN. flush_cnt=3.
- mem_busy=1 for 4 cycles in the second FLUSH cycle → all enables=0 for 4 cycles, then the remaining flush cycle completes. memwait_cnt=4.
- branch_taken and luh asserted together → flush only, no stall cycle. Branch with mem_busy=1 → freeze first, flush after mem_busy falls.
- rst asserted in FLUSH with counter=2 → next cycle state=RUN, counters=0. After rst falls, normal enables with no residual flush.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM state encoding,
// default register-address width and the pipeline-control bundles driven per cycle.
package hazard_pkg;

    localparam int unsigned DefRegAddrW = 3;
    localparam int unsigned FlushCntW   = 3;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StFlush   = 2'd1,
        StMemWait = 2'd2
    } hazard_state_e;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_bubble;
        logic back_we;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CtrlReset  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam pipe_ctrl_t CtrlRun    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam pipe_ctrl_t CtrlStall  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam pipe_ctrl_t CtrlFlush  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam pipe_ctrl_t CtrlFreeze = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/hazard_perf_counters.sv
// Three saturating event counters (load-use stalls, flush cycles, memory-wait freezes),
// cleared by synchronous reset. Only instantiated when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_counters #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_inc_i,
    input  logic             flush_inc_i,
    input  logic             memwait_inc_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] memwait_cnt_o
);

    logic [CNT_W-1:0] stall_q, flush_q, memwait_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q   <= '0;
            flush_q   <= '0;
            memwait_q <= '0;
        end else begin
            if (stall_inc_i && stall_q != '1)     stall_q   <= stall_q + 1'b1;
            if (flush_inc_i && flush_q != '1)     flush_q   <= flush_q + 1'b1;
            if (memwait_inc_i && memwait_q != '1) memwait_q <= memwait_q + 1'b1;
        end
    end

    assign stall_cnt_o   = stall_q;
    assign flush_cnt_o   = flush_q;
    assign memwait_cnt_o = memwait_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use bubble, taken-branch flush and memory-busy freeze.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = DefRegAddrW,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_src_addr,
    input  logic [REG_ADDR_W-1:0] id_dst_addr,
    input  logic                  id_src_used,
    input  logic                  id_dst_used,
    input  logic [REG_ADDR_W-1:0] ex_dst_addr,
    input  logic                  ex_mem_read,
    input  logic                  branch_taken,
    input  logic                  mem_busy,
    output logic                  pc_we,
    output logic                  if_id_we,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  back_we,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      memwait_cnt
);

    localparam logic [FlushCntW-1:0] FlushInit = FlushCntW'(FLUSH_CYCLES - 1);

    hazard_state_e        state_q, state_d, resume_q, resume_d, eff_state;
    logic [FlushCntW-1:0] cnt_q, cnt_d;
    pipe_ctrl_t           ctrl;
    logic                 luh;

    assign luh = ex_mem_read & ((id_src_used & (id_src_addr == ex_dst_addr)) |
                                (id_dst_used & (id_dst_addr == ex_dst_addr)));

    always_comb begin
        ctrl     = CtrlRun;
        state_d  = state_q;
        cnt_d    = cnt_q;
        resume_d = resume_q;
        // On the first non-busy cycle of MEM_WAIT, the saved state's rules apply directly.
        eff_state = (state_q == StMemWait) ? resume_q : state_q;
        if (rst) begin
            ctrl     = CtrlReset;
            state_d  = StRun;
            cnt_d    = '0;
            resume_d = StRun;
        end else if (mem_busy) begin
            ctrl    = CtrlFreeze;
            state_d = StMemWait;
            if (state_q != StMemWait) begin
                resume_d = (state_q == StFlush) ? StFlush : StRun;
            end
        end else begin
            case (eff_state)
                StFlush: begin
                    ctrl = CtrlFlush;
                    if (cnt_q <= FlushCntW'(1)) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        state_d = StFlush;
                        cnt_d   = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = StRun;
                    if (branch_taken) begin
                        ctrl = CtrlFlush;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = StFlush;
                            cnt_d   = FlushInit;
                        end
                    end else if (luh) begin
                        ctrl = CtrlStall;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            cnt_q    <= '0;
            resume_q <= StRun;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            resume_q <= resume_d;
        end
    end

    assign pc_we        = ctrl.pc_we;
    assign if_id_we     = ctrl.if_id_we;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_bubble = ctrl.id_ex_bubble;
    assign back_we      = ctrl.back_we;
    assign state_o      = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic stall_inc, flush_inc, memwait_inc;

    // CtrlStall is produced only by a serviced load-use hazard.
    assign stall_inc   = (ctrl == CtrlStall);
    assign flush_inc   = ctrl.if_id_flush & ~rst;
    assign memwait_inc = mem_busy & ~rst;

    hazard_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_inc_i  (stall_inc),
        .flush_inc_i  (flush_inc),
        .memwait_inc_i(memwait_inc),
        .stall_cnt_o  (stall_cnt),
        .flush_cnt_o  (flush_cnt),
        .memwait_cnt_o(memwait_cnt)
    );
`else
    assign stall_cnt   = '0;
    assign flush_cnt   = '0;
    assign memwait_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with FLUSH_CYCLES=3; counter expectations
// follow HAZARD_PERF_CNT_EN (zero when undefined).
module tb_hazard_control_unit;

    localparam int unsigned AW = 3;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] id_src_addr, id_dst_addr, ex_dst_addr;
    logic          id_src_used, id_dst_used, ex_mem_read, branch_taken, mem_busy;
    logic          pc_we, if_id_we, if_id_flush, id_ex_bubble, back_we;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt, flush_cnt, memwait_cnt;

    int compared = 0;
    int mismatched = 0;

    // Control vectors ordered {pc_we, if_id_we, if_id_flush, id_ex_bubble, back_we}
    localparam logic [4:0] VRst    = 5'b00110;
    localparam logic [4:0] VRun    = 5'b11001;
    localparam logic [4:0] VStall  = 5'b00011;
    localparam logic [4:0] VFlush  = 5'b10111;
    localparam logic [4:0] VFreeze = 5'b00000;

    hazard_control_unit #(
        .REG_ADDR_W  (AW),
        .FLUSH_CYCLES(3),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_src_addr (id_src_addr),
        .id_dst_addr (id_dst_addr),
        .id_src_used (id_src_used),
        .id_dst_used (id_dst_used),
        .ex_dst_addr (ex_dst_addr),
        .ex_mem_read (ex_mem_read),
        .branch_taken(branch_taken),
        .mem_busy    (mem_busy),
        .pc_we       (pc_we),
        .if_id_we    (if_id_we),
        .if_id_flush (if_id_flush),
        .id_ex_bubble(id_ex_bubble),
        .back_we     (back_we),
        .state_o     (state_o),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .memwait_cnt (memwait_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] exp_ctrl, input logic [1:0] exp_st);
        logic [6:0] obs, exp_v;
        #1;
        obs   = {state_o, pc_we, if_id_we, if_id_flush, id_ex_bubble, back_we};
        exp_v = {exp_st, exp_ctrl};
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed state/ctrl %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk_cnt(input string tag, input int s, input int f, input int m);
        logic [3*CW-1:0] obs, exp_v;
`ifdef HAZARD_PERF_CNT_EN
        exp_v = {CW'(s), CW'(f), CW'(m)};
`else
        exp_v = '0;
        if (s + f + m < 0) exp_v = '1;
`endif
        obs = {stall_cnt, flush_cnt, memwait_cnt};
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed counters %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic idle_inputs();
        id_src_addr = '0; id_dst_addr = '0; ex_dst_addr = '0;
        id_src_used = 0; id_dst_used = 0; ex_mem_read = 0;
        branch_taken = 0; mem_busy = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        cyc();
        chk("reset_outputs", VRst, 2'd0);
        chk_cnt("reset_counters", 0, 0, 0);

        rst = 1'b0;
        chk("run_idle", VRun, 2'd0);
        cyc();

        // Load-use through src operand
        ex_mem_read = 1; ex_dst_addr = 3; id_src_addr = 3; id_src_used = 1;
        chk("luh_src", VStall, 2'd0);
        cyc();
        ex_mem_read = 0;
        chk("luh_src_release", VRun, 2'd0);
        cyc();
        chk_cnt("cnt_after_luh", 1, 0, 0);

        // dst match only counts when dst is read
        ex_mem_read = 1; id_src_addr = 5; id_dst_addr = 3; id_dst_used = 0;
        chk("dst_unused_no_stall", VRun, 2'd0);
        id_dst_used = 1;
        chk("dst_used_stall", VStall, 2'd0);
        cyc();
        id_src_addr = 3; id_src_used = 0; id_dst_used = 0;
        chk("src_unused_no_stall", VRun, 2'd0);
        idle_inputs();
        cyc();

        // Branch pulse: three flush cycles
        branch_taken = 1;
        chk("br_resolve", VFlush, 2'd0);
        cyc();
        branch_taken = 0;
        chk("br_flush1", VFlush, 2'd1);
        cyc();
        chk("br_flush2", VFlush, 2'd1);
        cyc();
        chk("br_done", VRun, 2'd0);
        chk_cnt("cnt_after_branch", 2, 3, 0);

        // Freeze for 4 cycles during the last flush cycle
        branch_taken = 1;
        chk("brf_resolve", VFlush, 2'd0);
        cyc();
        branch_taken = 0;
        chk("brf_flush1", VFlush, 2'd1);
        cyc();
        mem_busy = 1;
        chk("brf_freeze0", VFreeze, 2'd1);
        for (int i = 1; i < 4; i++) begin
            cyc();
            chk($sformatf("brf_freeze%0d", i), VFreeze, 2'd2);
        end
        cyc();
        mem_busy = 0;
        chk("brf_resume_flush", VFlush, 2'd2);
        cyc();
        chk("brf_done", VRun, 2'd0);
        chk_cnt("cnt_after_freeze", 2, 6, 4);

        // Branch and load-use together: flush wins
        branch_taken = 1; ex_mem_read = 1; ex_dst_addr = 2; id_src_addr = 2; id_src_used = 1;
        chk("br_luh_resolve", VFlush, 2'd0);
        cyc();
        idle_inputs();
        chk("br_luh_flush1", VFlush, 2'd1);
        cyc();
        chk("br_luh_flush2", VFlush, 2'd1);
        cyc();
        chk("br_luh_done", VRun, 2'd0);
        chk_cnt("cnt_after_br_luh", 2, 9, 4);

        // Branch while memory busy: freeze first, flush after
        branch_taken = 1; mem_busy = 1;
        chk("br_busy_freeze", VFreeze, 2'd0);
        cyc();
        mem_busy = 0;
        chk("br_busy_exit", VFlush, 2'd2);
        cyc();
        branch_taken = 0;
        chk("br_busy_flush1", VFlush, 2'd1);
        cyc();
        chk("br_busy_flush2", VFlush, 2'd1);
        cyc();
        chk("br_busy_done", VRun, 2'd0);
        chk_cnt("cnt_after_br_busy", 2, 12, 5);

        // Load-use held across a freeze is serviced on exit
        ex_mem_read = 1; ex_dst_addr = 6; id_dst_addr = 6; id_dst_used = 1; mem_busy = 1;
        chk("luh_busy_freeze", VFreeze, 2'd0);
        cyc();
        mem_busy = 0;
        chk("luh_busy_exit", VStall, 2'd2);
        cyc();
        idle_inputs();
        chk("luh_busy_done", VRun, 2'd0);
        cyc();
        chk_cnt("cnt_after_luh_busy", 3, 12, 6);

        // Reset mid-flush with counter 2
        branch_taken = 1;
        cyc();
        branch_taken = 0;
        chk("rstf_in_flush", VFlush, 2'd1);
        rst = 1;
        chk("rstf_forced", VRst, 2'd1);
        cyc();
        rst = 0;
        chk("rstf_run", VRun, 2'd0);
        chk_cnt("rstf_counters", 0, 0, 0);
        cyc();
        chk("rstf_no_residual", VRun, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
